// File: rtl/instr_encoder_loader.sv
// -----------------------------------------------------------------------------
// instr_encoder_loader
//   Packs symbolic instructions (ADD, ADDI, BEQ) into 32-bit RV32I machine
//   words and writes them sequentially into instruction memory. It is the
//   encoder counterpart of the control-unit decoder and lets a program be
//   loaded without a ROM image.
//
// Ports
//   clk_i         rising-edge clock
//   reset_i       synchronous, active-high reset
//   start_i       restart a load: clears pointer, count and flags; blocks
//                 any accept in the same cycle
//   in_valid_i    instruction fields valid
//   in_ready_o    accept when in_valid_i & in_ready_o
//   in_op_i       00 ADD, 01 ADDI, 10 BEQ, 11 illegal
//   in_rd_i       destination register (ignored for BEQ)
//   in_rs1_i      source register 1
//   in_rs2_i      source register 2 (ignored for ADDI)
//   in_imm_i      13-bit signed immediate (ADDI uses [11:0], BEQ byte offset)
//   in_last_i     last instruction of the program
//   imem_we_o     one-cycle write strobe, one cycle after the accept
//   imem_addr_o   word address of the write
//   imem_wdata_o  encoded instruction word
//   count_o       words written since start/reset
//   full_o        count_o == IMEM_DEPTH
//   done_o        last word written; held until start/reset
//   err_o         sticky error
//   err_code_o    01 imm out of range, 10 odd BEQ offset, 11 illegal op
// -----------------------------------------------------------------------------
module instr_encoder_loader #(
  parameter int IMEM_DEPTH = 64,
  parameter int ADDR_W     = $clog2(IMEM_DEPTH)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [1:0]        in_op_i,
  input  logic [4:0]        in_rd_i,
  input  logic [4:0]        in_rs1_i,
  input  logic [4:0]        in_rs2_i,
  input  logic [12:0]       in_imm_i,
  input  logic              in_last_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic [ADDR_W:0]   count_o,
  output logic              full_o,
  output logic              done_o,
  output logic              err_o,
  output logic [1:0]        err_code_o
);

  localparam int             CNT_W     = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(IMEM_DEPTH);

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_ADDI = 2'b01;
  localparam logic [1:0] OP_BEQ  = 2'b10;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_RANGE = 2'b01;
  localparam logic [1:0] ERR_ODD   = 2'b10;
  localparam logic [1:0] ERR_OP    = 2'b11;

  typedef enum logic [1:0] {
    S_LOAD,
    S_FULL,
    S_DONE,
    S_ERROR
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [1:0]          code_q, code_d;

  logic                accept;
  logic [31:0]         enc_word;
  logic [1:0]          chk_code;

  // Instruction packing; funct3 is 000 for all three opcodes.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    enc_word = '0;
    unique case (in_op_i)
      OP_ADD:  enc_word = {7'b0, in_rs2_i, in_rs1_i, 3'b000, in_rd_i, 7'b0110011};
      OP_ADDI: enc_word = {in_imm_i[11:0], in_rs1_i, 3'b000, in_rd_i, 7'b0010011};
      OP_BEQ:  enc_word = {in_imm_i[12], in_imm_i[10:5], in_rs2_i, in_rs1_i, 3'b000,
                           in_imm_i[4:1], in_imm_i[11], 7'b1100011};
      default: enc_word = '0;
    endcase
  end

  // ADDI fits in 12 bits only if bit 12 agrees with the sign bit 11.
  // BEQ's 13-bit range is always encodable, only alignment matters.
  always_comb begin
    chk_code = ERR_NONE;
    unique case (in_op_i)
      OP_ADDI: if (in_imm_i[12] != in_imm_i[11]) chk_code = ERR_RANGE;
      OP_BEQ:  if (in_imm_i[0])                  chk_code = ERR_ODD;
      OP_ADD:  chk_code = ERR_NONE;
      default: chk_code = ERR_OP;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    code_d  = code_q;

    in_ready_o = (state_q == S_LOAD) && !start_i;
    accept     = in_valid_i && in_ready_o;

    if (start_i) begin
      state_d = S_LOAD;
      ptr_d   = '0;
      count_d = '0;
      addr_d  = '0;
      wdata_d = '0;
      code_d  = ERR_NONE;
    end else if (accept) begin
      if (chk_code != ERR_NONE) begin
        code_d  = chk_code;
        state_d = S_ERROR;
      end else begin
        we_d    = 1'b1;
        addr_d  = ptr_q;
        wdata_d = enc_word;
        // Pointer wraps naturally at IMEM_DEPTH (power of two).
        ptr_d   = ptr_q + ADDR_W'(1);
        count_d = count_q + CNT_W'(1);
        if (in_last_i) begin
          state_d = S_DONE;
        end else if (count_q + CNT_W'(1) == DEPTH_CNT) begin
          state_d = S_FULL;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset_i) begin
      state_q <= S_LOAD;
      ptr_q   <= '0;
      count_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      code_q  <= ERR_NONE;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      code_q  <= code_d;
    end
  end

  assign imem_we_o    = we_q;
  assign imem_addr_o  = addr_q;
  assign imem_wdata_o = wdata_q;
  assign count_o      = count_q;
  assign full_o       = (count_q == DEPTH_CNT);
  assign done_o       = (state_q == S_DONE);
  assign err_o        = (state_q == S_ERROR);
  assign err_code_o   = code_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder_loader
//   Directed scenarios plus a randomized run against a behavioural model of
//   the loader. A 64-deep and a 4-deep instance share the same stimulus; the
//   model tracks the 64-deep one, the 4-deep one is used for the full case.
// -----------------------------------------------------------------------------
module tb_instr_encoder_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, in_valid, in_last;
  logic [1:0]  in_op;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [12:0] in_imm;

  logic        in_ready, imem_we, full, done, err;
  logic [5:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [6:0]  count;
  logic [1:0]  err_code;

  logic        ready4, we4, full4, done4, err4;
  logic [1:0]  addr4;
  logic [31:0] wdata4;
  logic [2:0]  count4;
  logic [1:0]  code4;

  instr_encoder_loader #(.IMEM_DEPTH(64)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_op_i(in_op), .in_rd_i(in_rd), .in_rs1_i(in_rs1), .in_rs2_i(in_rs2),
    .in_imm_i(in_imm), .in_last_i(in_last),
    .imem_we_o(imem_we), .imem_addr_o(imem_addr), .imem_wdata_o(imem_wdata),
    .count_o(count), .full_o(full), .done_o(done), .err_o(err), .err_code_o(err_code)
  );

  instr_encoder_loader #(.IMEM_DEPTH(4)) dut4 (
    .clk_i(clk), .reset_i(reset), .start_i(start),
    .in_valid_i(in_valid), .in_ready_o(ready4),
    .in_op_i(in_op), .in_rd_i(in_rd), .in_rs1_i(in_rs1), .in_rs2_i(in_rs2),
    .in_imm_i(in_imm), .in_last_i(in_last),
    .imem_we_o(we4), .imem_addr_o(addr4), .imem_wdata_o(wdata4),
    .count_o(count4), .full_o(full4), .done_o(done4), .err_o(err4), .err_code_o(code4)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model of the 64-deep loader.
  int          m_ptr, m_count, m_addr;
  bit          m_done, m_err, m_we;
  logic [31:0] m_wdata;
  logic [1:0]  m_code;

  function automatic bit m_ready();
    return !m_done && !m_err && (m_count != 64) && !start;
  endfunction

  function automatic logic [31:0] encode(input int op, input int rd, input int rs1,
                                         input int rs2, input int imm);
    longint u, w;
    u = longint'(imm) & 'h1FFF;
    case (op)
      0: w = rs2 * (2**20) + rs1 * (2**15) + rd * (2**7) + 'h33;
      1: w = (u & 'hFFF) * (2**20) + rs1 * (2**15) + rd * (2**7) + 'h13;
      2: w = ((u >> 12) & 1) * (longint'(1) << 31) + ((u >> 5) & 63) * (2**25)
           + rs2 * (2**20) + rs1 * (2**15) + ((u >> 1) & 15) * (2**8)
           + ((u >> 11) & 1) * (2**7) + 'h63;
      default: w = 0;
    endcase
    return w[31:0];
  endfunction

  function automatic logic [1:0] err_of(input int op, input int imm);
    if (op == 3) return 2'd3;
    if (op == 2 && (imm % 2 != 0)) return 2'd2;
    if (op == 1 && (imm < -2048 || imm > 2047)) return 2'd1;
    return 2'd0;
  endfunction

  task automatic model_edge();
    int imm_s;
    logic [1:0] c;
    bit acc;
    acc   = in_valid && m_ready();
    m_we  = 0;
    if (reset || start) begin
      m_ptr = 0; m_count = 0; m_done = 0; m_err = 0; m_code = 0;
      m_addr = 0; m_wdata = 0;
      return;
    end
    if (acc) begin
      imm_s = $signed(in_imm);
      c = err_of(int'(in_op), imm_s);
      if (c != 0) begin
        m_err = 1; m_code = c;
      end else begin
        m_we = 1; m_addr = m_ptr;
        m_wdata = encode(int'(in_op), int'(in_rd), int'(in_rs1), int'(in_rs2), imm_s);
        m_ptr = (m_ptr + 1) % 64;
        m_count++;
        if (in_last) m_done = 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input bit v, input int op, input int rd, input int rs1,
                       input int rs2, input int imm, input bit last);
    in_valid = v; in_op = 2'(op); in_rd = 5'(rd); in_rs1 = 5'(rs1);
    in_rs2 = 5'(rs2); in_imm = 13'(imm); in_last = last;
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1, 0, 3, 1, 2, 0, 0);
    tick(); tick();
    vectors++;
    if (imem_we !== 1'b0 || count !== 7'd0 || imem_addr !== 6'd0 || imem_wdata !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_regs: we=%0b count=%0d addr=%0d wdata=%h, required 0/0/0/0",
               imem_we, count, imem_addr, imem_wdata);
    end
    vectors++;
    if ({full, done, err, err_code} !== 5'b0 || {full4, done4, err4, code4, count4} !== 8'b0) begin
      miscompares++;
      $display("FAIL reset_flags: full=%0b done=%0b err=%0b code=%0b, required all 0",
               full, done, err, err_code);
    end
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_add();
    pulse_start();
    drive(1, 0, 3, 1, 2, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    vectors++;
    if (imem_we !== 1'b1 || imem_addr !== 6'd0 || imem_wdata !== 32'h002081B3 || count !== 7'd1) begin
      miscompares++;
      $display("FAIL add_word: we=%0b addr=%0d wdata=%h count=%0d, required 1/0/002081b3/1",
               imem_we, imem_addr, imem_wdata, count);
    end
    tick();
    vectors++;
    if (imem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL add_single_strobe: we=%0b, required 0", imem_we);
    end
  endtask

  task automatic test_back_to_back();
    pulse_start();
    drive(1, 1, 1, 0, 0, 5, 0);
    tick();
    drive(1, 2, 0, 1, 2, -8, 1);
    vectors++;
    if (imem_we !== 1'b1 || imem_addr !== 6'd0 || imem_wdata !== 32'h00500093) begin
      miscompares++;
      $display("FAIL b2b_addi: we=%0b addr=%0d wdata=%h, required 1/0/00500093",
               imem_we, imem_addr, imem_wdata);
    end
    tick();
    drive(1, 0, 4, 4, 4, 0, 0);
    vectors++;
    if (imem_we !== 1'b1 || imem_addr !== 6'd1 || imem_wdata !== 32'hFE208CE3 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_beq: we=%0b addr=%0d wdata=%h done=%0b, required 1/1/fe208ce3/1",
               imem_we, imem_addr, imem_wdata, done);
    end
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_ready_after_done: in_ready=%0b, required 0", in_ready);
    end
    tick();
    vectors++;
    if (imem_we !== 1'b0 || count !== 7'd2 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_hold: we=%0b count=%0d done=%0b, required 0/2/1", imem_we, count, done);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_errors();
    int ops[6]  = '{1, 2, 3, 1, 1, 2};
    int imms[6] = '{2048, 3, 0, -2049, -2048, -4096};
    logic [1:0] codes[6] = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd0, 2'd0};
    for (int i = 0; i < 6; i++) begin
      pulse_start();
      drive(1, ops[i], 7, 9, 11, imms[i], 0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0);
      vectors++;
      if (err !== (codes[i] != 0) || err_code !== codes[i] || imem_we !== (codes[i] == 0)) begin
        miscompares++;
        $display("FAIL err_case%0d: err=%0b code=%0b we=%0b, required %0b/%0b/%0b",
                 i, err, err_code, imem_we, codes[i] != 0, codes[i], codes[i] == 0);
      end
      if (codes[i] != 0) begin
        vectors++;
        if (in_ready !== 1'b0 || count !== 7'd0) begin
          miscompares++;
          $display("FAIL err_blocks%0d: in_ready=%0b count=%0d, required 0/0", i, in_ready, count);
        end
      end else begin
        vectors++;
        if (imem_wdata !== encode(ops[i], 7, 9, 11, imms[i])) begin
          miscompares++;
          $display("FAIL err_boundary_word%0d: wdata=%h, required %h",
                   i, imem_wdata, encode(ops[i], 7, 9, 11, imms[i]));
        end
      end
    end
  endtask

  task automatic test_full();
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, i + 1, 0, 0, 0, 0);
      tick();
      vectors++;
      if (we4 !== 1'b1 || addr4 !== 2'(i) || full4 !== (i == 3)) begin
        miscompares++;
        $display("FAIL full_write%0d: we=%0b addr=%0d full=%0b, required 1/%0d/%0b",
                 i, we4, addr4, full4, i, i == 3);
      end
    end
    vectors++;
    if (ready4 !== 1'b0 || count4 !== 3'd4 || done4 !== 1'b0) begin
      miscompares++;
      $display("FAIL full_state: ready=%0b count=%0d done=%0b, required 0/4/0", ready4, count4, done4);
    end
    tick();
    vectors++;
    if (we4 !== 1'b0 || count4 !== 3'd4 || full4 !== 1'b1) begin
      miscompares++;
      $display("FAIL full_ignore: we=%0b count=%0d full=%0b, required 0/4/1", we4, count4, full4);
    end
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 5, 6, 7, 0, i == 3);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    vectors++;
    if (we4 !== 1'b1 || addr4 !== 2'd3 || done4 !== 1'b1 || full4 !== 1'b1) begin
      miscompares++;
      $display("FAIL full_last: we=%0b addr=%0d done=%0b full=%0b, required 1/3/1/1",
               we4, addr4, done4, full4);
    end
  endtask

  task automatic test_start_priority();
    pulse_start();
    drive(1, 0, 1, 2, 3, 0, 1);
    tick();
    start = 1'b1;
    drive(1, 0, 8, 8, 8, 0, 0);
    vectors++;
    if (done !== 1'b1 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL start_ready: done=%0b in_ready=%0b, required 1/0", done, in_ready);
    end
    tick();
    start = 1'b0;
    vectors++;
    if (imem_we !== 1'b0 || count !== 7'd0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL start_clear: we=%0b count=%0d done=%0b, required 0/0/0", imem_we, count, done);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    vectors++;
    if (imem_we !== 1'b1 || imem_addr !== 6'd0 || count !== 7'd1) begin
      miscompares++;
      $display("FAIL start_readdr: we=%0b addr=%0d count=%0d, required 1/0/1", imem_we, imem_addr, count);
    end
  endtask

  task automatic test_reset_after_accept();
    pulse_start();
    drive(1, 1, 2, 3, 0, 100, 0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    vectors++;
    if (imem_we !== 1'b0 || count !== 7'd0 || {full, done, err, err_code} !== 5'b0 || imem_addr !== 6'd0) begin
      miscompares++;
      $display("FAIL reset_after_accept: we=%0b count=%0d flags=%0b addr=%0d, required 0/0/0/0",
               imem_we, count, {full, done, err, err_code}, imem_addr);
    end
  endtask

  task automatic test_random();
    int imm_pool[8] = '{-2049, -2048, 2047, 2048, 0, -1, 4095, -4096};
    int imm, op;
    bit exp_ready;
    pulse_start();
    for (int n = 0; n < 400; n++) begin
      start = ($urandom_range(0, 99) < 6);
      op  = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
      imm = ($urandom_range(0, 1) == 0) ? imm_pool[$urandom_range(0, 7)]
                                        : int'($urandom_range(0, 8191)) - 4096;
      if (op == 2 && $urandom_range(0, 3) != 0) imm = imm & ~1;
      drive($urandom_range(0, 9) < 7, op, int'($urandom_range(0, 31)),
            int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), imm,
            $urandom_range(0, 99) < 4);
      exp_ready = m_ready();
      vectors++;
      if (in_ready !== exp_ready) begin
        miscompares++;
        $display("FAIL rnd_ready@%0d: in_ready=%0b, required %0b", n, in_ready, exp_ready);
      end
      tick();
      vectors++;
      if (imem_we !== m_we || count !== 7'(m_count) || full !== (m_count == 64) ||
          done !== m_done || err !== m_err || err_code !== m_code) begin
        miscompares++;
        $display("FAIL rnd_state@%0d: we=%0b count=%0d full=%0b done=%0b err=%0b code=%0b, required %0b/%0d/%0b/%0b/%0b/%0b",
                 n, imem_we, count, full, done, err, err_code,
                 m_we, m_count, m_count == 64, m_done, m_err, m_code);
      end
      if (m_we) begin
        vectors++;
        if (imem_addr !== 6'(m_addr) || imem_wdata !== m_wdata) begin
          miscompares++;
          $display("FAIL rnd_write@%0d: addr=%0d wdata=%h, required %0d/%h",
                   n, imem_addr, imem_wdata, m_addr, m_wdata);
        end
      end
    end
    start = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0;
    in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_imm = '0; in_last = 1'b0;
    m_ptr = 0; m_count = 0; m_addr = 0; m_done = 0; m_err = 0; m_we = 0;
    m_wdata = '0; m_code = '0;
    test_reset();
    test_add();
    test_back_to_back();
    test_errors();
    test_full();
    test_start_priority();
    test_reset_after_accept();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
